sprite_blitter: RTL and testbench

- Parametrised successor to the fixed 2x sprite drawer: reads a sprite image (header plus pixels) from an external ROM mux and streams pixels to the LT24Display pixel interface.
- Adds runtime integer scale 1..MAX_SCALE, a parametrised colour key, a parametrised clip window and frame-to-LCD offset, and a done pulse.
- Sits between game/menu control logic and LT24Display; one instance per display.

---
 rtl/sprite_blitter_pkg.sv | 15 +
 rtl/blit_addr_gen.sv | 108 ++++++++++
 rtl/sprite_blitter.sv | 154 +++++++++++++++
 tb/tb_sprite_blitter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_blitter_pkg.sv
// Shared types and constants for the sprite blitter: FSM states, header layout
// and the default colour key.
package sprite_blitter_pkg;

    typedef enum logic [3:0] {
        IDLE, READY, HDR_W, HDR_H, FETCH, EMIT, WAIT, NEXT, FINISH
    } blit_state_t;

    localparam int HDR_WIDTH_ADDR  = 0;
    localparam int HDR_HEIGHT_ADDR = 1;
    localparam int PIXEL_BASE_ADDR = 2;

    localparam logic [15:0] TRANSPARENT_DEFAULT = 16'h0001;

endpackage

// File: rtl/blit_addr_gen.sv
// Sprite walk counters: source ROM address, signed frame coordinates of the
// current sub-pixel and the clip-window test.
module blit_addr_gen
    import sprite_blitter_pkg::*;
#(
    parameter int X_WIDTH    = 8,
    parameter int Y_WIDTH    = 9,
    parameter int ADDR_WIDTH = 16,
    parameter int SVW        = 3,
    parameter int CLIP_X_MIN = 0,
    parameter int CLIP_X_MAX = 239,
    parameter int CLIP_Y_MIN = 100,
    parameter int CLIP_Y_MAX = 419
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         step_sub,
    input  logic                         step_pix,
    input  logic [X_WIDTH-1:0]           x_origin,
    input  logic [Y_WIDTH-1:0]           y_origin,
    input  logic [SVW-1:0]               s_in,
    input  logic                         mirror_in,
    input  logic [Y_WIDTH-1:0]           img_width,
    input  logic [X_WIDTH-1:0]           img_height,
    output logic [ADDR_WIDTH-1:0]        rom_addr,
    output logic signed [X_WIDTH+1:0]    frame_x,
    output logic signed [Y_WIDTH+1:0]    frame_y,
    output logic                         in_clip,
    output logic                         sub_last,
    output logic                         pix_last
);

    localparam logic signed [X_WIDTH+1:0] XMIN = (X_WIDTH+2)'(CLIP_X_MIN);
    localparam logic signed [X_WIDTH+1:0] XMAX = (X_WIDTH+2)'(CLIP_X_MAX);
    localparam logic signed [Y_WIDTH+1:0] YMIN = (Y_WIDTH+2)'(CLIP_Y_MIN);
    localparam logic signed [Y_WIDTH+1:0] YMAX = (Y_WIDTH+2)'(CLIP_Y_MAX);

    logic [X_WIDTH-1:0]        r;
    logic [Y_WIDTH-1:0]        c, y_org, col;
    logic [SVW-1:0]            sx, sy, s_lat;
    logic                      mir, row_end, sy_end;
    logic [ADDR_WIDTH-1:0]     row_base;
    logic signed [X_WIDTH+1:0] x_row;
    logic signed [Y_WIDTH+1:0] y_col;

    assign row_end  = (c == img_width - 1'b1);
    assign sy_end   = (sy == s_lat - 1'b1);
    assign sub_last = sy_end && (sx == s_lat - 1'b1);
    assign pix_last = row_end && (r == img_height - 1'b1);
    assign col      = mir ? (img_width - 1'b1 - c) : c;
    assign rom_addr = row_base + ADDR_WIDTH'(col);
    assign frame_x  = x_row - (X_WIDTH+2)'(sx);
    assign frame_y  = y_col + (Y_WIDTH+2)'(sy);
    assign in_clip  = (frame_x >= XMIN) && (frame_x <= XMAX) &&
                      (frame_y >= YMIN) && (frame_y <= YMAX);

    // Row/column bases stop moving once past the coordinate range, so a long
    // sprite can never wrap back into the window.
    always_ff @(posedge clock) begin
        if (reset) begin
            r        <= '0;
            c        <= '0;
            sx       <= '0;
            sy       <= '0;
            s_lat    <= SVW'(1);
            mir      <= 1'b0;
            row_base <= '0;
            x_row    <= '0;
            y_col    <= '0;
            y_org    <= '0;
        end else if (start) begin
            r        <= '0;
            c        <= '0;
            sx       <= '0;
            sy       <= '0;
            s_lat    <= s_in;
            mir      <= mirror_in;
            row_base <= ADDR_WIDTH'(PIXEL_BASE_ADDR);
            x_row    <= (X_WIDTH+2)'(x_origin);
            y_col    <= (Y_WIDTH+2)'(y_origin);
            y_org    <= y_origin;
        end else if (step_sub) begin
            if (sy_end) begin
                sy <= '0;
                sx <= sx + 1'b1;
            end else begin
                sy <= sy + 1'b1;
            end
        end else if (step_pix) begin
            sx <= '0;
            sy <= '0;
            if (row_end) begin
                c        <= '0;
                r        <= r + 1'b1;
                row_base <= row_base + ADDR_WIDTH'(img_width);
                y_col    <= (Y_WIDTH+2)'(y_org);
                if (!x_row[X_WIDTH+1])
                    x_row <= x_row - (X_WIDTH+2)'(s_lat);
            end else begin
                c <= c + 1'b1;
                if (!y_col[Y_WIDTH])
                    y_col <= y_col + (Y_WIDTH+2)'(s_lat);
            end
        end
    end

endmodule

// File: rtl/sprite_blitter.sv
// Scaled, colour-keyed, clipped sprite blitter from ROM to the LT24 pixel port.
// Define SPRITE_BLITTER_MIRROR_EN to add the horizontal-flip 'mirror' input.
module sprite_blitter
    import sprite_blitter_pkg::*;
#(
    parameter int X_WIDTH     = 8,
    parameter int Y_WIDTH     = 9,
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int MAX_SCALE   = 4,
    parameter int ROM_LATENCY = 2,
    parameter logic [DATA_WIDTH-1:0] TRANSPARENT = DATA_WIDTH'(TRANSPARENT_DEFAULT),
    parameter int Y_OFFSET    = 100,
    parameter int CLIP_X_MIN  = 0,
    parameter int CLIP_X_MAX  = 239,
    parameter int CLIP_Y_MIN  = 100,
    parameter int CLIP_Y_MAX  = 419,
    localparam int SCALE_W    = (MAX_SCALE > 1) ? $clog2(MAX_SCALE) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [X_WIDTH-1:0]    xOrigin,
    input  logic [Y_WIDTH-1:0]    yOrigin,
    input  logic [SCALE_W-1:0]    scale,
    input  logic                  draw,
    output logic                  ready,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] romAddr,
    input  logic [DATA_WIDTH-1:0] romData,
    output logic [Y_WIDTH-1:0]    imgWidth,
    output logic [X_WIDTH-1:0]    imgHeight,
    output logic [X_WIDTH-1:0]    xAddr,
    output logic [Y_WIDTH-1:0]    yAddr,
    output logic [DATA_WIDTH-1:0] pixelData,
    output logic                  pixelWrite,
    input  logic                  pixelReady
`ifdef SPRITE_BLITTER_MIRROR_EN
    ,
    input  logic                  mirror
`endif
);

    localparam int SVW   = $clog2(MAX_SCALE + 1);
    localparam int LAT_W = $clog2(ROM_LATENCY + 2);

    blit_state_t               state, state_next;
    logic [LAT_W-1:0]          lat_cnt;
    logic                      lat_done, start, step_sub, step_pix, emit_write;
    logic                      mirror_sel, in_clip, sub_last, pix_last;
    logic [DATA_WIDTH-1:0]     colour;
    logic [SVW-1:0]            s_val;
    logic [ADDR_WIDTH-1:0]     gen_addr;
    logic signed [X_WIDTH+1:0] frame_x;
    logic signed [Y_WIDTH+1:0] frame_y;

`ifdef SPRITE_BLITTER_MIRROR_EN
    assign mirror_sel = mirror;
`else
    assign mirror_sel = 1'b0;
`endif

    assign s_val      = SVW'(scale) + SVW'(1);
    assign lat_done   = (lat_cnt == LAT_W'(ROM_LATENCY));
    assign emit_write = (colour != TRANSPARENT) && in_clip;
    assign done       = (state == FINISH);

    blit_addr_gen #(
        .X_WIDTH(X_WIDTH), .Y_WIDTH(Y_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .SVW(SVW),
        .CLIP_X_MIN(CLIP_X_MIN), .CLIP_X_MAX(CLIP_X_MAX),
        .CLIP_Y_MIN(CLIP_Y_MIN), .CLIP_Y_MAX(CLIP_Y_MAX)
    ) u_addr_gen (
        .clock(clock), .reset(reset), .start(start),
        .step_sub(step_sub), .step_pix(step_pix),
        .x_origin(xOrigin), .y_origin(yOrigin), .s_in(s_val), .mirror_in(mirror_sel),
        .img_width(imgWidth), .img_height(imgHeight),
        .rom_addr(gen_addr), .frame_x(frame_x), .frame_y(frame_y),
        .in_clip(in_clip), .sub_last(sub_last), .pix_last(pix_last)
    );

    always_comb begin
        case (state)
            HDR_H:   romAddr = ADDR_WIDTH'(HDR_HEIGHT_ADDR);
            FETCH:   romAddr = gen_addr;
            default: romAddr = ADDR_WIDTH'(HDR_WIDTH_ADDR);
        endcase
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        step_sub   = 1'b0;
        step_pix   = 1'b0;
        case (state)
            IDLE:   if (!draw) state_next = READY;
            READY:  if (draw) begin
                        state_next = HDR_W;
                        start      = 1'b1;
                    end
            HDR_W:  if (lat_done) state_next = HDR_H;
            HDR_H:  if (lat_done)
                        state_next = (imgWidth == '0 || romData[X_WIDTH-1:0] == '0) ? FINISH : FETCH;
            FETCH:  if (lat_done) state_next = EMIT;
            EMIT:   if (emit_write) state_next = WAIT;
                    else if (sub_last) state_next = NEXT;
                    else step_sub = 1'b1;
            WAIT:   if (pixelReady) begin
                        if (sub_last) state_next = NEXT;
                        else begin
                            step_sub   = 1'b1;
                            state_next = EMIT;
                        end
                    end
            NEXT:   if (pix_last) state_next = FINISH;
                    else begin
                        step_pix   = 1'b1;
                        state_next = FETCH;
                    end
            FINISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // lat_cnt restarts on every state change, so it measures time since romAddr moved.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            ready      <= 1'b0;
            imgWidth   <= '0;
            imgHeight  <= '0;
            colour     <= '0;
            xAddr      <= '0;
            yAddr      <= '0;
            pixelData  <= '0;
            pixelWrite <= 1'b0;
        end else begin
            state   <= state_next;
            lat_cnt <= (state_next != state) ? '0 : lat_cnt + 1'b1;
            ready   <= (state_next == IDLE) || (state_next == READY);
            if (state == HDR_W && lat_done) imgWidth  <= romData[Y_WIDTH-1:0];
            if (state == HDR_H && lat_done) imgHeight <= romData[X_WIDTH-1:0];
            if (state == FETCH && lat_done) colour    <= romData;
            if (state == EMIT && emit_write) begin
                pixelWrite <= 1'b1;
                xAddr      <= X_WIDTH'(frame_x);
                yAddr      <= Y_WIDTH'(frame_y - (Y_WIDTH+2)'(Y_OFFSET));
                pixelData  <= colour;
            end else if (pixelWrite && pixelReady) begin
                pixelWrite <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: ROM model with 2-cycle latency, write
// capture on the falling edge, hand-computed expected pixel lists.
module tb_sprite_blitter;

    localparam logic [15:0] CA = 16'hAAAA, CB = 16'hBBBB, CC = 16'hCCCC, CD = 16'hDDDD;

    logic        clock = 1'b0, reset = 1'b1;
    logic [7:0]  xOrigin = '0;
    logic [8:0]  yOrigin = '0;
    logic [1:0]  scale = '0;
    logic        draw = 1'b0, pixelReady = 1'b1;
    logic        ready, done, pixelWrite;
    logic [15:0] romAddr, romData, pixelData;
    logic [8:0]  imgWidth, yAddr;
    logic [7:0]  imgHeight, xAddr;

    logic [15:0] rom [0:15];
    logic [15:0] rd1, rd2;
    logic [32:0] wq[$];
    int          done_cnt = 0, viol = 0;
    logic        prev_acc = 1'b0;
    int          total = 0, bad = 0;
    logic [15:0] rom_seen;
    logic        rom_high;

    sprite_blitter dut (
        .clock(clock), .reset(reset), .xOrigin(xOrigin), .yOrigin(yOrigin),
        .scale(scale), .draw(draw), .ready(ready), .done(done),
        .romAddr(romAddr), .romData(romData), .imgWidth(imgWidth), .imgHeight(imgHeight),
        .xAddr(xAddr), .yAddr(yAddr), .pixelData(pixelData),
        .pixelWrite(pixelWrite), .pixelReady(pixelReady)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        rd1 <= (romAddr < 16'd16) ? rom[romAddr[3:0]] : 16'h0000;
        rd2 <= rd1;
    end
    assign romData = rd2;

    always @(negedge clock) begin
        if (!reset) begin
            if (pixelWrite && pixelReady) wq.push_back({xAddr, yAddr, pixelData});
            if (prev_acc && pixelWrite) viol++;
            if (done) done_cnt++;
        end
        prev_acc = !reset && pixelWrite && pixelReady;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] pk(input int x, input int y, input logic [15:0] d);
        logic [7:0] xs;
        logic [8:0] ys;
        xs = x[7:0];
        ys = y[8:0];
        return {xs, ys, d};
    endfunction

    function automatic logic [32:0] wq_at(input int i);
        if (i < wq.size()) return wq[i];
        return '1;
    endfunction

    task automatic run_draw(input logic [7:0] xo, input logic [8:0] yo,
                            input logic [1:0] sc, input bit hold);
        int n, d0;
        d0 = done_cnt;
        xOrigin = xo; yOrigin = yo; scale = sc; draw = 1'b1;
        n = 0;
        do begin tick(); n++; end while (ready && n < 20);
        if (!hold) draw = 1'b0;
        rom_seen = '0;
        rom_high = 1'b0;
        n = 0;
        while (done_cnt == d0 && n < 4000) begin
            if (!ready) begin
                if (romAddr > 16'd15) rom_high = 1'b1;
                else rom_seen[romAddr[3:0]] = 1'b1;
            end
            tick();
            n++;
        end
        check("draw_timeout", 64'(n >= 4000), 64'(0));
        tick(); tick();
    endtask

    initial begin
        int base, d0, n, unstable, idx;
        logic [7:0]  hx;
        logic [8:0]  hy;
        logic [15:0] hd;
        logic [15:0] colv [0:3];
        colv[0] = CA; colv[1] = CB; colv[2] = CC; colv[3] = CD;
        for (int i = 0; i < 16; i++) rom[i] = 16'h0;
        rom[0] = 16'd2; rom[1] = 16'd2;
        rom[2] = CA; rom[3] = CB; rom[4] = CC; rom[5] = CD;

        // reset state
        tick(); tick();
        check("rst_ready", 64'(ready), 64'(0));
        check("rst_pixelWrite", 64'(pixelWrite), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_romAddr", 64'(romAddr), 64'(0));
        check("rst_xy", 64'({xAddr, yAddr, pixelData}), 64'(0));
        reset = 1'b0;
        tick(); tick();
        check("idle_ready", 64'(ready), 64'(1));

        // 2x2, scale 1
        base = wq.size(); d0 = done_cnt;
        run_draw(8'd50, 9'd150, 2'd0, 1'b0);
        check("t1_count", 64'(wq.size() - base), 64'(4));
        check("t1_A", 64'(wq_at(base + 0)), 64'(pk(50, 50, CA)));
        check("t1_B", 64'(wq_at(base + 1)), 64'(pk(50, 51, CB)));
        check("t1_C", 64'(wq_at(base + 2)), 64'(pk(49, 50, CC)));
        check("t1_D", 64'(wq_at(base + 3)), 64'(pk(49, 51, CD)));
        check("t1_done_once", 64'(done_cnt - d0), 64'(1));
        check("t1_imgWidth", 64'(imgWidth), 64'(2));
        check("t1_imgHeight", 64'(imgHeight), 64'(2));

        // 2x2, scale 2: each pixel becomes a 2x2 block, sy fastest
        base = wq.size();
        run_draw(8'd50, 9'd150, 2'd1, 1'b0);
        check("t2_count", 64'(wq.size() - base), 64'(16));
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                for (int sx = 0; sx < 2; sx++)
                    for (int sy = 0; sy < 2; sy++) begin
                        idx = (r * 2 + c) * 4 + sx * 2 + sy;
                        check("t2_pix", 64'(wq_at(base + idx)),
                              64'(pk(50 - r * 2 - sx, 50 + c * 2 + sy, colv[r * 2 + c])));
                    end
        check("t2_rom_addrs", 64'(rom_seen), 64'(16'h003F));
        check("t2_rom_high", 64'(rom_high), 64'(0));

        // transparent pixel B
        rom[3] = 16'h0001;
        base = wq.size();
        run_draw(8'd50, 9'd150, 2'd0, 1'b0);
        check("t3_count", 64'(wq.size() - base), 64'(3));
        check("t3_A", 64'(wq_at(base + 0)), 64'(pk(50, 50, CA)));
        check("t3_C", 64'(wq_at(base + 1)), 64'(pk(49, 50, CC)));
        check("t3_D", 64'(wq_at(base + 2)), 64'(pk(49, 51, CD)));
        rom[3] = CB;

        // 3x3 at (1,418): row 2 lands on x=-1, column 2 on y=420, both clipped
        rom[0] = 16'd3; rom[1] = 16'd3;
        for (int i = 0; i < 9; i++) rom[2 + i] = 16'h1000 + 16'(i);
        base = wq.size(); d0 = done_cnt;
        run_draw(8'd1, 9'd418, 2'd0, 1'b0);
        check("t4_count", 64'(wq.size() - base), 64'(4));
        check("t4_r0c0", 64'(wq_at(base + 0)), 64'(pk(1, 318, 16'h1000)));
        check("t4_r0c1", 64'(wq_at(base + 1)), 64'(pk(1, 319, 16'h1001)));
        check("t4_r1c0", 64'(wq_at(base + 2)), 64'(pk(0, 318, 16'h1003)));
        check("t4_r1c1", 64'(wq_at(base + 3)), 64'(pk(0, 319, 16'h1004)));
        check("t4_done", 64'(done_cnt - d0), 64'(1));
        rom[0] = 16'd2; rom[1] = 16'd2;
        rom[2] = CA; rom[3] = CB; rom[4] = CC; rom[5] = CD;

        // stall: pixelReady low for 10 cycles with the first write pending
        pixelReady = 1'b0;
        base = wq.size(); d0 = done_cnt;
        xOrigin = 8'd50; yOrigin = 9'd150; scale = 2'd0; draw = 1'b1;
        tick();
        draw = 1'b0;
        n = 0;
        while (!pixelWrite && n < 50) begin tick(); n++; end
        check("t5_pw_rise", 64'(pixelWrite), 64'(1));
        hx = xAddr; hy = yAddr; hd = pixelData;
        unstable = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (pixelWrite !== 1'b1 || xAddr !== hx || yAddr !== hy || pixelData !== hd)
                unstable++;
        end
        check("t5_stable", 64'(unstable), 64'(0));
        check("t5_held_value", 64'({hx, hy, hd}), 64'(pk(50, 50, CA)));
        check("t5_no_write_stalled", 64'(wq.size() - base), 64'(0));
        pixelReady = 1'b1;
        n = 0;
        while (done_cnt == d0 && n < 4000) begin tick(); n++; end
        check("t5_timeout", 64'(n >= 4000), 64'(0));
        tick(); tick();
        check("t5_count", 64'(wq.size() - base), 64'(4));
        check("t5_first", 64'(wq_at(base)), 64'(pk(50, 50, CA)));

        // reset mid-sprite
        pixelReady = 1'b0;
        base = wq.size(); d0 = done_cnt;
        draw = 1'b1;
        tick();
        draw = 1'b0;
        n = 0;
        while (!pixelWrite && n < 50) begin tick(); n++; end
        check("t6_pw_rise", 64'(pixelWrite), 64'(1));
        reset = 1'b1;
        tick();
        check("t6_pw_after_reset", 64'(pixelWrite), 64'(0));
        reset = 1'b0;
        pixelReady = 1'b1;
        repeat (40) tick();
        check("t6_no_writes", 64'(wq.size() - base), 64'(0));
        check("t6_no_done", 64'(done_cnt - d0), 64'(0));

        // zero-width header
        rom[0] = 16'd0;
        base = wq.size(); d0 = done_cnt;
        run_draw(8'd50, 9'd150, 2'd0, 1'b0);
        check("t7_no_writes", 64'(wq.size() - base), 64'(0));
        check("t7_done", 64'(done_cnt - d0), 64'(1));
        check("t7_imgWidth", 64'(imgWidth), 64'(0));
        rom[0] = 16'd2;

        // held draw must not retrigger
        base = wq.size(); d0 = done_cnt;
        run_draw(8'd50, 9'd150, 2'd0, 1'b1);
        repeat (30) tick();
        check("t8_single_done", 64'(done_cnt - d0), 64'(1));
        check("t8_single_writes", 64'(wq.size() - base), 64'(4));
        check("t8_ready_idle", 64'(ready), 64'(1));
        draw = 1'b0;
        tick(); tick();
        run_draw(8'd50, 9'd150, 2'd0, 1'b0);
        check("t8_second_done", 64'(done_cnt - d0), 64'(2));
        check("t8_second_writes", 64'(wq.size() - base), 64'(8));

        check("write_spacing", 64'(viol), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
